led_toggle_bank: RTL
====================

# led_toggle_bank

N-channel push-button front end that replaces the fixed three-button debouncer/toggler top level with one parametrised block. It synchronises raw buttons, debounces them against an internal sample tick, and detects press and long-press events. Each LED output is driven in a per-channel runtime-selected mode. It sits directly between board button pins and LED pins, or any logic that consumes clean press events.

## Interface
- NUM_CH, 3, number of button/LED channels (≥1)
- TICK_DIV, 50000, Clk cycles per debounce sample tick (≥2)
- DB_SAMPLES, 4, consecutive differing samples required to accept a new level (≥1)
- LONG_TICKS, 1000, ticks a debounced press must last to count as a long press (>DB_SAMPLES)

- Clk  in  1  single system clock; all state on rising edge
- Rst  in  1  synchronous, active-high reset
- ButtonIn  in  NUM_CH  raw asynchronous buttons, active-high
- Mode  in  2*NUM_CH  per-channel mode, channel i at bits [2i+1:2i]
- Led  out  NUM_CH  registered LED drive
- PressPulse  out  NUM_CH  one-cycle pulse on debounced rising edge
- LongPulse  out  NUM_CH  one-cycle pulse when a press reaches LONG_TICKS
- Tick  out  1  one-cycle sample strobe, for observability

## Operation
- Sync: 2-flop synchroniser per channel; downstream logic sees only the synchronised value `s`.
- Tick generator: counter 0..TICK_DIV-1, wraps to 0; Tick=1 in the cycle the count equals TICK_DIV-1.
- Debounce per channel, evaluated only on Tick:
  - `s==stable`: cnt←0.
  - Else if cnt==DB_SAMPLES-1: stable←s and cnt←0.
  - Else: cnt←cnt+1.
- Edges: rise = stable & ~stable_d; fall = ~stable & stable_d. PressPulse is registered rise.
- Hold counter:
  - Cleared while stable=0.
  - Increments on Tick while stable=1 and saturates at LONG_TICKS.
  - LongPulse fires once, on the cycle after the count first reaches LONG_TICKS. A long flag is set at the same time and cleared on fall.
- Modes (Led is a register):
  - 00 toggle: Led inverts on rise.
  - 01 momentary: Led←stable.
  - 10 short/long: on fall with long flag clear, Led inverts. On LongPulse, Led←0.
  - 11: behaves as 00.
- Mode change takes effect on the next clock. Entering 01 forces Led=stable next cycle. Leaving 01 keeps the current Led value.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.

## Timing
- Reset values: Led=0, PressPulse=0, LongPulse=0, Tick=0. Tick counter, sync flops, stable, cnt, hold counter and long flag all 0.
- Rst mid-operation overrides all events in that cycle. A button held through reset is seen as a new press after debounce.
- Latency, ButtonIn rise → PressPulse: 2 sync cycles + wait to next Tick + (DB_SAMPLES-1) further Ticks + 2 cycles (stable update, then edge register).
- Led changes in the same cycle as PressPulse (modes 00/01), or as the fall-edge cycle (mode 10 release).
- Glitch rule: a level shorter than DB_SAMPLES consecutive samples is never accepted, and its cnt is reset.
- Counter widths: $clog2 of TICK_DIV, DB_SAMPLES and LONG_TICKS+1. No wrap on the hold counter.

## Structure
- Package led_bank_pkg: mode constants MODE_TOGGLE=2'b00, MODE_MOMENTARY=2'b01, MODE_SHORTLONG=2'b10.
- Sub-module btn_channel: synchroniser, debounce, edge detect, hold counter and Led logic for one channel. It is instantiated NUM_CH times in a generate loop.
- The tick generator is inline in the top and shared by all channels.

## Test plan
Bench parameters: TICK_DIV=4, DB_SAMPLES=3, LONG_TICKS=8.
- Reset with ButtonIn=0 → all outputs 0. Tick first asserts at cycle 3 after Rst release, then every 4 cycles.
- Mode 00, ch0 press held 40 cycles → exactly one PressPulse and Led[0]=1. A second press gives Led[0]=0.
- 1-tick (4-cycle) glitch on ch1 → no PressPulse and Led unchanged. A 2-tick glitch also produces no pulse.
- Mode 01, ch2 press held 20 cycles then released → Led[2] follows stable, high for the debounced duration.
- Mode 10:
  - Press shorter than 8 ticks → Led toggles on release, no LongPulse.
  - Press of 12 ticks → one LongPulse and Led=0, no toggle on release.
- All channels pressed simultaneously, with Rst asserted mid-debounce → nothing fires. After Rst release the presses are re-debounced and each channel pulses once.

Source files
------------

// File: rtl/led_bank_pkg.sv
// Shared constants and helpers for the led_toggle_bank push-button front end.
package led_bank_pkg;

    localparam logic [1:0] MODE_TOGGLE    = 2'b00;
    localparam logic [1:0] MODE_MOMENTARY = 2'b01;
    localparam logic [1:0] MODE_SHORTLONG = 2'b10;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button/LED lane: synchroniser, tick-sampled debounce, edge detect,
// long-press hold counter and mode-selected LED register.
module btn_channel
    import led_bank_pkg::*;
#(
    parameter int DB_SAMPLES = 4,
    parameter int LONG_TICKS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       button,
    input  logic [1:0] mode,
    output logic       led,
    output logic       press_pulse,
    output logic       long_pulse
);

    localparam int DW = cnt_width(DB_SAMPLES);
    localparam int HW = cnt_width(LONG_TICKS + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DB_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

    logic [1:0]    sync_r;
    logic          stable_r;
    logic          stable_d_r;
    logic [DW-1:0] cnt_r;
    logic [HW-1:0] hold_r;
    logic          long_r;
    logic          led_r;
    logic          press_r;
    logic          long_pulse_r;

    logic          stable_nx_s;
    logic [DW-1:0] cnt_nx_s;
    logic [HW-1:0] hold_nx_s;
    logic          long_nx_s;
    logic          led_nx_s;
    logic          rise_s;
    logic          fall_s;
    logic          long_hit_s;

    assign rise_s     = stable_r & ~stable_d_r;
    assign fall_s     = ~stable_r & stable_d_r;
    // Long press can only be declared while the button is still held.
    assign long_hit_s = stable_r & (hold_r == HOLD_MAX) & ~long_r;

    // Next-state for debounce, hold counter, long flag and LED.
    always_comb begin
        stable_nx_s = stable_r;
        cnt_nx_s    = cnt_r;
        hold_nx_s   = hold_r;
        long_nx_s   = long_r;
        led_nx_s    = led_r;

        if (!tick) begin
            cnt_nx_s = cnt_r;
        end else if (sync_r[1] == stable_r) begin
            cnt_nx_s = {DW{1'b0}};
        end else if (cnt_r == DB_LAST) begin
            stable_nx_s = sync_r[1];
            cnt_nx_s    = {DW{1'b0}};
        end else begin
            cnt_nx_s = cnt_r + DW'(1);
        end

        if (!stable_r) begin
            hold_nx_s = {HW{1'b0}};
        end else if (tick && (hold_r != HOLD_MAX)) begin
            hold_nx_s = hold_r + HW'(1);
        end else begin
            hold_nx_s = hold_r;
        end

        if (long_hit_s) begin
            long_nx_s = 1'b1;
        end else if (fall_s) begin
            long_nx_s = 1'b0;
        end else begin
            long_nx_s = long_r;
        end

        case (mode)
            MODE_MOMENTARY: led_nx_s = stable_r;
            MODE_SHORTLONG: begin
                if (long_hit_s) begin
                    led_nx_s = 1'b0;
                end else if (fall_s && !long_r) begin
                    led_nx_s = ~led_r;
                end else begin
                    led_nx_s = led_r;
                end
            end
            default: begin
                if (rise_s) begin
                    led_nx_s = ~led_r;
                end else begin
                    led_nx_s = led_r;
                end
            end
        endcase
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r       <= 2'b00;
            stable_r     <= 1'b0;
            stable_d_r   <= 1'b0;
            cnt_r        <= {DW{1'b0}};
            hold_r       <= {HW{1'b0}};
            long_r       <= 1'b0;
            led_r        <= 1'b0;
            press_r      <= 1'b0;
            long_pulse_r <= 1'b0;
        end else begin
            sync_r       <= {sync_r[0], button};
            stable_r     <= stable_nx_s;
            stable_d_r   <= stable_r;
            cnt_r        <= cnt_nx_s;
            hold_r       <= hold_nx_s;
            long_r       <= long_nx_s;
            led_r        <= led_nx_s;
            press_r      <= rise_s;
            long_pulse_r <= long_hit_s;
        end
    end

    assign led         = led_r;
    assign press_pulse = press_r;
    assign long_pulse  = long_pulse_r;

endmodule

// File: rtl/led_toggle_bank.sv
// N-channel debounced button / LED front end sharing one sample-tick generator.
module led_toggle_bank
    import led_bank_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int TICK_DIV   = 50000,
    parameter int DB_SAMPLES = 4,
    parameter int LONG_TICKS = 1000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NUM_CH-1:0]     ButtonIn,
    input  logic [2*NUM_CH-1:0]   Mode,
    output logic [NUM_CH-1:0]     Led,
    output logic [NUM_CH-1:0]     PressPulse,
    output logic [NUM_CH-1:0]     LongPulse,
    output logic                  Tick
);

    localparam int TW = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt_r;
    logic [TW-1:0] tick_cnt_nx_s;
    logic          tick_r;

    // Tick is registered from the next count so it is high while count == TICK_DIV-1.
    always_comb begin
        tick_cnt_nx_s = tick_cnt_r;
        if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_nx_s = {TW{1'b0}};
        end else begin
            tick_cnt_nx_s = tick_cnt_r + TW'(1);
        end
    end

    // Shared sample-tick counter and strobe.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tick_cnt_r <= {TW{1'b0}};
            tick_r     <= 1'b0;
        end else begin
            tick_cnt_r <= tick_cnt_nx_s;
            tick_r     <= (tick_cnt_nx_s == TICK_LAST);
        end
    end

    assign Tick = tick_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_channel #(
            .DB_SAMPLES (DB_SAMPLES),
            .LONG_TICKS (LONG_TICKS)
        ) u_ch (
            .clk         (Clk),
            .rst         (Rst),
            .tick        (tick_r),
            .button      (ButtonIn[i]),
            .mode        (Mode[2*i +: 2]),
            .led         (Led[i]),
            .press_pulse (PressPulse[i]),
            .long_pulse  (LongPulse[i])
        );
    end

endmodule
